// File: rtl/hbmc_bus_arb_pkg.sv
// hbmc_bus_arb_pkg: shared state encoding and helpers for the HBMC bus-sync arbiter
`timescale 1ns/1ps
package hbmc_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/hbmc_rr_pick.sv
// hbmc_rr_pick: combinational round-robin picker, first valid at or above ptr with wrap
`timescale 1ns/1ps
module hbmc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // explicit compare so non-power-of-2 N wraps correctly
    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    // scan from ptr upward, keep the first hit
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && valid[wrap(int'(ptr) + k)]) begin
                any                          = 1'b1;
                idx                          = IW'(wrap(int'(ptr) + k));
                grant[wrap(int'(ptr) + k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hbmc_bus_sync_arb.sv
// hbmc_bus_sync_arb: round-robin arbiter feeding one four-phase bus synchronizer; optional ack watchdog via HBMC_BUS_ARB_TIMEOUT_EN
`timescale 1ns/1ps
module hbmc_bus_sync_arb
    import hbmc_bus_arb_pkg::*;
#(
    parameter int C_NUM_REQ        = 4,
    parameter int C_DATA_WIDTH     = 8,
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [C_NUM_REQ-1:0]                         req_valid,
    output logic [C_NUM_REQ-1:0]                         req_ready,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0]            req_data,
    output logic [C_DATA_WIDTH+clog2(C_NUM_REQ)-1:0]     bus_data,
    output logic                                         bus_req,
    input  logic                                         bus_ack,
    output logic                                         busy,
    output logic                                         timeout_err
);

    localparam int ID_W = clog2(C_NUM_REQ);
    localparam int BW   = C_DATA_WIDTH + ID_W;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, pick_idx;
    logic [C_NUM_REQ-1:0] pick_grant;
    logic              pick_any, take, bus_req_d;
    logic [BW-1:0]     bus_data_d;

    hbmc_rr_pick #(.N(C_NUM_REQ), .IW(ID_W)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // a grant needs idle, no lingering ack, and reset released
    assign take      = rstn && state_q == ST_IDLE && !bus_ack && pick_any;
    assign req_ready = take ? pick_grant : '0;
    assign busy      = state_q != ST_IDLE;

`ifdef HBMC_BUS_ARB_TIMEOUT_EN
    localparam int CW = clog2(C_TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // next-state, pointer and bus-side register values
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bus_req_d  = bus_req;
        bus_data_d = bus_data;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d    = ST_REQ;
                ptr_d      = (pick_idx == ID_W'(C_NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                bus_req_d  = 1'b1;
                bus_data_d = {pick_idx, req_data[int'(pick_idx)*C_DATA_WIDTH +: C_DATA_WIDTH]};
            end
            ST_REQ: if (bus_ack) begin
                state_d   = ST_REL;
                bus_req_d = 1'b0;
            end
            ST_REL: if (!bus_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef HBMC_BUS_ARB_TIMEOUT_EN
        terr_d = terr_q;
        cnt_d  = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        if (state_q != ST_IDLE && state_d == state_q && cnt_q == CW'(C_TIMEOUT_CYCLES - 1)) begin
            terr_d    = 1'b1;
            bus_req_d = 1'b0;
            state_d   = ST_REL;
            cnt_d     = '0;
        end
`endif
    end

    // state and bus registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            bus_req  <= 1'b0;
            bus_data <= '0;
`ifdef HBMC_BUS_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            bus_req  <= bus_req_d;
            bus_data <= bus_data_d;
`ifdef HBMC_BUS_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
`endif
        end
    end

endmodule

// File: tb/tb_hbmc_bus_sync_arb.sv
// tb_hbmc_bus_sync_arb: directed self-checking bench for the round-robin bus-sync arbiter
`timescale 1ns/1ps
module tb_hbmc_bus_sync_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [9:0]  bus_data;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic        timeout_err;
    int          passed = 0;
    int          total = 0;

    hbmc_bus_sync_arb #(.C_NUM_REQ(4), .C_DATA_WIDTH(8), .C_TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .bus_data    (bus_data),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // one full four-phase transaction for requester id, starting in idle at posedge+1
    task automatic txn(input int id, input logic [7:0] pl);
        logic [9:0] exp_data;
        exp_data = {id[1:0], pl};
        #1 check("grant_ready", 32'(req_ready), 32'(4'b0001 << id));
        tick();
        check("req_rise", 32'(bus_req), 1);
        check("req_data", 32'(bus_data), 32'(exp_data));
        check("ready_off_req", 32'(req_ready), 0);
        repeat (3) tick();
        check("data_stable", 32'(bus_data), 32'(exp_data));
        check("req_held", 32'(bus_req), 1);
        bus_ack = 1'b1;
        tick();
        check("req_fall", 32'(bus_req), 0);
        check("busy_rel", 32'(busy), 1);
        check("ready_off_rel", 32'(req_ready), 0);
        bus_ack = 1'b0;
        tick();
        check("idle_again", 32'(busy), 0);
    endtask

    initial begin
        req_valid = 4'hF;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_req", 32'(bus_req), 0);
        check("rst_data", 32'(bus_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_terr", 32'(timeout_err), 0);
        rstn = 1'b1;
        txn(0, 8'h11);
        txn(1, 8'h22);
        txn(2, 8'h33);
        txn(3, 8'h44);
        txn(0, 8'h11);
        req_valid = 4'b0100;
        txn(2, 8'h33);
        txn(2, 8'h33);
        txn(2, 8'h33);
        req_valid = 4'b1001;
        txn(3, 8'h44);
        rstn = 1'b0;
        req_valid = 4'hF;
        tick();
        bus_ack = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ack_hold_ready", 32'(req_ready), 0);
            check("ack_hold_req", 32'(bus_req), 0);
        end
        bus_ack = 1'b0;
        #1 check("ack_clear_grant", 32'(req_ready), 32'(4'b0001));
        tick();
        check("mid_req_up", 32'(bus_req), 1);
        rstn = 1'b0;
        tick();
        check("mid_rst_req", 32'(bus_req), 0);
        check("mid_rst_busy", 32'(busy), 0);
        bus_ack = 1'b1;
        rstn = 1'b1;
        #1 check("stale_ack_ready", 32'(req_ready), 0);
        tick();
        check("stale_ack_ready2", 32'(req_ready), 0);
        check("stale_ack_req", 32'(bus_req), 0);
        bus_ack = 1'b0;
        #1 check("post_stale_grant", 32'(req_ready), 32'(4'b0001));
        tick();
        check("wd_req_up", 32'(bus_req), 1);
`ifdef HBMC_BUS_ARB_TIMEOUT_EN
        repeat (15) tick();
        check("wd_pre_terr", 32'(timeout_err), 0);
        check("wd_pre_req", 32'(bus_req), 1);
        tick();
        check("wd_terr", 32'(timeout_err), 1);
        check("wd_req_drop", 32'(bus_req), 0);
        tick();
        check("wd_idle", 32'(busy), 0);
        check("wd_resume", 32'(req_ready), 32'(4'b0010));
        check("wd_sticky", 32'(timeout_err), 1);
`else
        repeat (40) tick();
        check("nowd_req", 32'(bus_req), 1);
        check("nowd_terr", 32'(timeout_err), 0);
        check("nowd_busy", 32'(busy), 1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hbmc_bus_sync_arb.md
Name: hbmc_bus_sync_arb

Overview:
- Round-robin arbiter sharing one bus-synchronizer channel between C_NUM_REQ source-domain requesters.
- Accepts words over per-requester valid/ready, tags each word with the requester index, and drives the synchronizer's four-phase req/ack source port.
- Sits in the source clock domain, directly in front of the synchronizer's src_data/src_req/src_ack.

Parameters:
- C_NUM_REQ, 4, number of requesters; range 2..16.
- C_DATA_WIDTH, 8, payload width per requester.
- C_TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  source-domain clock; sole clock.
- rstn  in  1  reset; synchronous, active-low.
- req_valid  in  C_NUM_REQ  per-requester word valid.
- req_ready  out  C_NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  C_NUM_REQ*C_DATA_WIDTH  flattened payloads; requester i at bits [i*W +: W].
- bus_data  out  C_DATA_WIDTH+ID_W  {id, payload} to synchronizer src_data; ID_W = clog2(C_NUM_REQ).
- bus_req  out  1  four-phase request to synchronizer src_req.
- bus_ack  in  1  synchronized acknowledge from synchronizer src_ack.
- busy  out  1  high whenever state != ST_IDLE.
- timeout_err  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset (rstn=0 at posedge):
  - bus_req=0, bus_data=0, busy=0, timeout_err=0.
  - RR pointer=0, state=ST_IDLE.
  - req_ready=0 while rstn=0.
- Reset mid-handshake: bus_req drops to 0 at the next edge. The block then waits in ST_IDLE for bus_ack=0 before any new grant, so a stale ack is never taken as a new one.
- ST_IDLE:
  - Grant: first i with req_valid[i]=1, scanning from pointer upward and wrapping modulo C_NUM_REQ.
  - Grant issued only if any valid and bus_ack=0. req_ready[grant]=1 combinationally in that same cycle.
  - On that edge: bus_data <= {grant, req_data[grant]}, bus_req <= 1, pointer <= (grant+1) mod C_NUM_REQ, state -> ST_REQ.
  - No valid or bus_ack=1: hold state; pointer unchanged.
- ST_REQ:
  - bus_req and bus_data held stable.
  - When bus_ack=1: bus_req <= 0, state -> ST_REL.
- ST_REL:
  - When bus_ack=0: state -> ST_IDLE. The next grant is possible in the following cycle.
- Throughput: minimum 3 clk per word plus synchronizer round-trip. bus_req rises 1 clk after acceptance.
- req_ready is never asserted outside ST_IDLE. A requester deasserting valid before its grant is legal and loses nothing.
- Pointer rule: the pointer moves only on a grant, never on idle cycles. A single continuously-valid requester is granted every transaction.
- Non-power-of-2 C_NUM_REQ: wrap uses an explicit compare, not bit truncation. Id field is zero-extended to ID_W.
- Simultaneous events:
  - Valids arriving in ST_REQ/ST_REL wait.
  - bus_ack rising and falling across consecutive cycles follows the states in order; no state is skipped.

Optional Feature:
- Macro: HBMC_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ST_REQ and ST_REL and increments each cycle in those states.
  - Reaching C_TIMEOUT_CYCLES-1 sets timeout_err (sticky until reset), forces bus_req <= 0 and goes to ST_REL.
  - The word is dropped.
- Undefined: no counter; timeout_err constant 0; the block waits indefinitely.

Decomposition:
- Package hbmc_bus_arb_pkg:
  - state encoding ST_IDLE/ST_REQ/ST_REL (2-bit);
  - clog2 function for ID_W.
- One sub-module, hbmc_rr_pick: combinational round-robin picker.
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reused by other HBMC arbiters.

Test Plan:
- Reset with req_valid=4'b1111 -> req_ready=0, bus_req=0, bus_data=0. After release, first grant is index 0 with bus_data={2'd0,payload0}.
- All four valid continuously, ack loopback with 4-cycle delay -> grants in order 0,1,2,3,0. Exactly one req_ready pulse per transaction; bus_data stable while bus_req=1.
- Only req_valid[2] high for 3 words -> three consecutive grants to 2; pointer=3 after each grant.
- Hold bus_ack=1 after reset -> no grant until bus_ack=0. Then a grant occurs the next cycle.
- Assert rstn=0 in ST_REQ -> bus_req=0 next edge; no req_ready pulse until bus_ack returns 0.
- With HBMC_BUS_ARB_TIMEOUT_EN and C_TIMEOUT_CYCLES=16, bus_ack stuck 0 -> timeout_err=1 at cycle 16, bus_req=0, arbitration resumes. Without the macro, bus_req stays 1 and timeout_err stays 0.
